// File: rtl/scaler_pkg.sv
// Shared types, defaults and the reciprocal table for the ping-pong line scaler.
package scaler_pkg;

   localparam int DEF_DW = 10;
   localparam int DEF_CH = 3;

   typedef enum logic {
      MODE_DROP = 1'b0,
      MODE_AVG  = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_PRIME = 2'd1,
      RD_RUN   = 2'd2
   } rd_state_e;

   // ceil(65536/n): multiply-and-shift replaces a divide by the group size
   function automatic logic [16:0] recip(input logic [3:0] n);
      case (n)
         4'd1:    recip = 17'd65536;
         4'd2:    recip = 17'd32768;
         4'd3:    recip = 17'd21846;
         4'd4:    recip = 17'd16384;
         4'd5:    recip = 17'd13108;
         4'd6:    recip = 17'd10923;
         4'd7:    recip = 17'd9363;
         4'd8:    recip = 17'd8192;
         default: recip = 17'd0;
      endcase
   endfunction

endpackage

// File: rtl/pingpong_line_ram.sv
// Two line banks: the write port owns bank wr_bank, the read port owns the other one.
module pingpong_line_ram #(
   parameter int W     = 30,
   parameter int DEPTH = 640,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          wr_bank,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [W-1:0]  q0, q1;

   assign we0   = we & ~wr_bank;
   assign we1   = we & wr_bank;
   assign addr0 = wr_bank ? rd_addr : wr_addr;
   assign addr1 = wr_bank ? wr_addr : rd_addr;
   // Banks only swap while the reader is idle, so the live wr_bank selects read data safely
   assign rd_data = wr_bank ? q0 : q1;

   single_port_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
      .clk(clk), .we(we0), .addr(addr0), .wdata(wr_data), .rdata(q0)
   );

   single_port_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
      .clk(clk), .we(we1), .addr(addr1), .wdata(wr_data), .rdata(q1)
   );

endmodule

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
module single_port_ram #(
   parameter int W     = 30,
   parameter int DEPTH = 640,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/line_scaler_pp.sv
// Horizontal/vertical downscaler with drop or box-average and ping-pong line banks.
// o_de/o_data is a valid-only stream: no ready, downstream must accept every o_de cycle.
module line_scaler_pp
   import scaler_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int CH        = DEF_CH,
   parameter int HMAX      = 640,
   parameter int MAX_RATIO = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [$clog2(MAX_RATIO+1)-1:0] i_ratio,
   input  logic                           i_mode,
   input  logic                           i_vsync,
   input  logic                           i_hsync,
   input  logic                           i_de,
   input  logic [CH*DW-1:0]               i_data,
   output logic                           o_vsync,
   output logic                           o_hsync,
   output logic                           o_de,
   output logic [CH*DW-1:0]               o_data,
   output logic                           o_ovf,
   output rd_state_e                      dbg_rd_state
);

   localparam int AW = $clog2(HMAX);
   localparam int RW = $clog2(MAX_RATIO+1);
   localparam int SW = DW + $clog2(MAX_RATIO);
   localparam int PW = SW + 17;
   localparam logic [AW:0] HMAX_C = (AW+1)'(HMAX);

   mode_e               mode_q;
   logic [RW-1:0]       ratio_q, v_phase, grp, avg_n;
   logic [AW:0]         h_cnt, wr_cnt, rd_len, n_out;
   logic                wr_bank, de_q, vs_d1, vs_d2;
   logic [CH-1:0][SW-1:0] acc, grp_sum;
   logic [16:0]         rc;
   logic                vs_rise, de_fall, kept, pix_ok, grp_last, partial, wr_en;
   logic                line_done, rd_start;
   logic [CH*DW-1:0]    wr_data, ram_q;

   rd_state_e           state, state_nx;
   logic [AW-1:0]       rd_addr, rd_addr_nx, rd_bus;
   logic                ram_rd, rd_valid, hsync_nx;

   assign vs_rise   = i_vsync & ~vs_d1;
   assign de_fall   = de_q & ~i_de;
   assign kept      = (v_phase == '0);
   assign pix_ok    = i_de & kept & (h_cnt < HMAX_C);
   assign grp_last  = (grp == ratio_q - RW'(1));
   assign partial   = de_fall & kept & (mode_q == MODE_AVG) & (grp != '0);
   assign wr_en     = partial | (pix_ok & ((mode_q == MODE_DROP) ? (grp == '0) : grp_last));
   assign n_out     = wr_cnt + {{AW{1'b0}}, partial};
   assign line_done = de_fall & kept & (n_out != '0);
   assign rd_start  = line_done & (state == RD_IDLE);

   always_comb begin : avg_path
      logic [SW-1:0] px;
      logic [SW-1:0] sum;
      logic [PW-1:0] rnd;
      avg_n   = partial ? grp : ratio_q;
      rc      = recip(4'(avg_n));
      wr_data = '0;
      grp_sum = '0;
      px      = '0;
      sum     = '0;
      rnd     = '0;
      for (int c = 0; c < CH; c++) begin
         px         = SW'(i_data[c*DW +: DW]);
         grp_sum[c] = (grp == '0) ? px : acc[c] + px;
         // The partial group at line end already sits in acc; no pixel arrives that cycle
         sum        = partial ? acc[c] : grp_sum[c];
         rnd        = PW'(sum) * PW'(rc) + PW'(32768);
         if (rnd[PW-1:16+DW] != '0) wr_data[c*DW +: DW] = '1;
         else                       wr_data[c*DW +: DW] = rnd[16 +: DW];
      end
      if (mode_q == MODE_DROP) wr_data = i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ratio_q <= RW'(1);
         mode_q  <= MODE_DROP;
         v_phase <= '0;
         grp     <= '0;
         h_cnt   <= '0;
         wr_cnt  <= '0;
         rd_len  <= '0;
         wr_bank <= 1'b0;
         de_q    <= 1'b0;
         vs_d1   <= 1'b0;
         vs_d2   <= 1'b0;
         acc     <= '0;
         o_ovf   <= 1'b0;
      end else begin
         vs_d1 <= i_vsync;
         vs_d2 <= vs_d1;
         de_q  <= i_de;
         if (vs_rise) begin
            if (i_ratio == '0 || i_ratio > RW'(MAX_RATIO)) ratio_q <= RW'(1);
            else                                            ratio_q <= i_ratio;
            mode_q <= mode_e'(i_mode);
         end
         if (i_de && h_cnt < HMAX_C) h_cnt <= h_cnt + (AW+1)'(1);
         if (pix_ok) begin
            grp <= grp_last ? '0 : grp + RW'(1);
            acc <= grp_sum;
         end
         if (wr_en) wr_cnt <= wr_cnt + (AW+1)'(1);
         if (de_fall) begin
            h_cnt   <= '0;
            grp     <= '0;
            wr_cnt  <= '0;
            v_phase <= (v_phase >= ratio_q - RW'(1)) ? '0 : v_phase + RW'(1);
            if (rd_start) begin
               wr_bank <= ~wr_bank;
               rd_len  <= n_out;
            end else if (line_done) begin
               o_ovf <= 1'b1;
            end
         end
         if (vs_rise) v_phase <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RD_IDLE;
         rd_addr  <= '0;
         rd_valid <= 1'b0;
         o_hsync  <= 1'b0;
         o_de     <= 1'b0;
         o_data   <= '0;
      end else begin
         state    <= state_nx;
         rd_addr  <= rd_addr_nx;
         rd_valid <= ram_rd;
         o_hsync  <= hsync_nx;
         o_de     <= rd_valid;
         o_data   <= rd_valid ? ram_q : '0;
      end
   end

   always_comb begin
      state_nx   = state;
      rd_addr_nx = rd_addr;
      rd_bus     = rd_addr;
      ram_rd     = 1'b0;
      hsync_nx   = 1'b0;
      case (state)
         RD_IDLE: begin
            if (rd_start) state_nx = RD_PRIME;
         end
         RD_PRIME: begin
            ram_rd     = 1'b1;
            rd_bus     = '0;
            hsync_nx   = 1'b1;
            rd_addr_nx = AW'(1);
            state_nx   = (rd_len == (AW+1)'(1)) ? RD_IDLE : RD_RUN;
         end
         RD_RUN: begin
            ram_rd     = 1'b1;
            rd_addr_nx = rd_addr + AW'(1);
            if ({1'b0, rd_addr} == rd_len - (AW+1)'(1)) state_nx = RD_IDLE;
         end
         default: state_nx = RD_IDLE;
      endcase
   end

   pingpong_line_ram #(.W(CH*DW), .DEPTH(HMAX), .AW(AW)) u_ram (
      .clk(clk),
      .wr_bank(wr_bank),
      .we(wr_en),
      .wr_addr(wr_cnt[AW-1:0]),
      .wr_data(wr_data),
      .rd_addr(rd_bus),
      .rd_data(ram_q)
   );

   assign o_vsync      = vs_d2;
   assign dbg_rd_state = state;

endmodule

// File: tb/tb_line_scaler_pp.sv
// Scoreboard bench for line_scaler_pp: expected words queued at stimulus, checked at o_de.
module tb_line_scaler_pp;
   import scaler_pkg::*;

   localparam int DW        = 10;
   localparam int CH        = 3;
   localparam int HMAX      = 640;
   localparam int MAX_RATIO = 4;
   localparam int RW        = $clog2(MAX_RATIO+1);
   localparam int W         = CH*DW;

   logic            clk, rst;
   logic [RW-1:0]   i_ratio;
   logic            i_mode, i_vsync, i_hsync, i_de;
   logic [W-1:0]    i_data;
   logic            o_vsync, o_hsync, o_de, o_ovf;
   logic [W-1:0]    o_data;
   rd_state_e       dbg_rd_state;

   logic [W-1:0]    exp_q[$];
   logic [W-1:0]    line_buf [HMAX+8];
   int              n_checks = 0;
   int              n_fail = 0;
   int              m_ratio, m_vphase;
   bit              m_mode;
   logic            prev_de = 1'b0;
   logic            prev_hs = 1'b0;
   logic [W-1:0]    exp_w;

   line_scaler_pp #(.DW(DW), .CH(CH), .HMAX(HMAX), .MAX_RATIO(MAX_RATIO)) dut (
      .clk(clk), .rst(rst), .i_ratio(i_ratio), .i_mode(i_mode),
      .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data),
      .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data),
      .o_ovf(o_ovf), .dbg_rd_state(dbg_rd_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (o_de) begin
            if (!prev_de) begin
               n_checks++;
               if (prev_hs !== 1'b1) begin
                  $display("FAIL hsync_lead: o_hsync before first o_de = %b, required 1", prev_hs);
                  n_fail++;
               end
            end
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_word: o_data = %0h with no word expected", o_data);
               n_fail++;
            end else begin
               exp_w = exp_q.pop_front();
               if (o_data !== exp_w) begin
                  $display("FAIL o_data: got %0h, required %0h", o_data, exp_w);
                  n_fail++;
               end
            end
         end else begin
            n_checks++;
            if (o_data !== '0) begin
               $display("FAIL o_data_idle: got %0h while o_de=0, required 0", o_data);
               n_fail++;
            end
         end
         prev_de = o_de;
         prev_hs = o_hsync;
      end else begin
         prev_de = 1'b0;
         prev_hs = 1'b0;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_start(input int r, input bit m);
      i_ratio = RW'(r);
      i_mode  = m;
      i_vsync = 1'b1;
      tick();
      n_checks++;
      if (o_vsync !== 1'b0) begin
         $display("FAIL vsync_delay1: o_vsync = %b, required 0", o_vsync);
         n_fail++;
      end
      tick();
      n_checks++;
      if (o_vsync !== 1'b1) begin
         $display("FAIL vsync_delay2: o_vsync = %b, required 1", o_vsync);
         n_fail++;
      end
      i_vsync = 1'b0;
      tick();
      tick();
      m_ratio  = (r == 0 || r > MAX_RATIO) ? 1 : r;
      m_mode   = m;
      m_vphase = 0;
   endtask

   task automatic fill_pattern(input int line, input int n);
      logic [W-1:0] w;
      for (int x = 0; x < n; x++) begin
         w = '0;
         for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'(line*16 + x + c*100);
         line_buf[x] = w;
      end
   endtask

   task automatic model_line(input int n, input bit push);
      int nn, cnt;
      longint sum, rcp, a;
      logic [W-1:0] w;
      nn = (n > HMAX) ? HMAX : n;
      if (push && m_vphase == 0) begin
         for (int g = 0; g < nn; g += m_ratio) begin
            if (!m_mode) begin
               exp_q.push_back(line_buf[g]);
            end else begin
               cnt = (nn - g < m_ratio) ? nn - g : m_ratio;
               w = '0;
               for (int c = 0; c < CH; c++) begin
                  sum = 0;
                  for (int k = 0; k < cnt; k++) sum += longint'(line_buf[g+k][c*DW +: DW]);
                  rcp = (65536 + cnt - 1) / cnt;
                  a = (sum * rcp + 32768) >> 16;
                  if (a > (1 << DW) - 1) a = (1 << DW) - 1;
                  w[c*DW +: DW] = DW'(a);
               end
               exp_q.push_back(w);
            end
         end
      end
      m_vphase = (m_vphase + 1) % m_ratio;
   endtask

   task automatic send_line(input int n, input bit push);
      model_line(n, push);
      for (int x = 0; x < n; x++) begin
         i_de   = 1'b1;
         i_data = line_buf[x];
         tick();
      end
      i_de   = 1'b0;
      i_data = '0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
         n_fail++;
      end
      exp_q.delete();
      repeat (4) tick();
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({o_vsync, o_hsync, o_de, o_ovf} !== 4'b0 || o_data !== '0) begin
         $display("FAIL reset_outputs: vs/hs/de/ovf = %b%b%b%b data = %0h, required all 0",
                  o_vsync, o_hsync, o_de, o_ovf, o_data);
         n_fail++;
      end
      n_checks++;
      if (dbg_rd_state !== RD_IDLE) begin
         $display("FAIL reset_state: got %0d, required %0d", dbg_rd_state, RD_IDLE);
         n_fail++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ratio1_drop();
      frame_start(1, 1'b0);
      for (int l = 0; l < 4; l++) begin
         fill_pattern(l, 10);
         send_line(10, 1'b1);
         if (l == 0) begin
            tick();
            n_checks++;
            if (o_hsync !== 1'b0 || o_de !== 1'b0) begin
               $display("FAIL lat_t0: hs/de = %b%b, required 00", o_hsync, o_de);
               n_fail++;
            end
            tick();
            n_checks++;
            if (o_hsync !== 1'b1 || o_de !== 1'b0) begin
               $display("FAIL lat_t1: hs/de = %b%b, required 10", o_hsync, o_de);
               n_fail++;
            end
            tick();
            n_checks++;
            if (o_hsync !== 1'b0 || o_de !== 1'b1) begin
               $display("FAIL lat_t2: hs/de = %b%b, required 01", o_hsync, o_de);
               n_fail++;
            end
            repeat (2) tick();
         end else begin
            repeat (5) tick();
         end
      end
      wait_drain();
   endtask

   task automatic test_ratio2_drop();
      frame_start(2, 1'b0);
      for (int l = 0; l < 4; l++) begin
         fill_pattern(l, 10);
         send_line(10, 1'b1);
         repeat (5) tick();
      end
      wait_drain();
   endtask

   task automatic test_avg_partial();
      logic [W-1:0] w;
      int outs [4];
      outs = '{3, 12, 21, 27};
      frame_start(3, 1'b1);
      for (int x = 0; x < 10; x++) begin
         w = '0;
         w[0 +: DW]  = DW'(3*x);
         w[DW +: DW] = DW'(3*x);
         line_buf[x] = w;
      end
      for (int k = 0; k < 4; k++) begin
         w = '0;
         w[0 +: DW]  = DW'(outs[k]);
         w[DW +: DW] = DW'(outs[k]);
         exp_q.push_back(w);
      end
      send_line(10, 1'b0);
      repeat (5) tick();
      wait_drain();
   endtask

   task automatic test_avg_sat();
      frame_start(4, 1'b1);
      for (int x = 0; x < 10; x++) line_buf[x] = '1;
      repeat (3) exp_q.push_back('1);
      send_line(10, 1'b0);
      repeat (5) tick();
      wait_drain();
   endtask

   task automatic test_ratio_change();
      frame_start(2, 1'b0);
      for (int l = 0; l < 4; l++) begin
         if (l == 1) begin
            i_ratio = RW'(3);
            i_mode  = 1'b1;
         end
         fill_pattern(l, 10);
         send_line(10, 1'b1);
         repeat (5) tick();
      end
      wait_drain();
      frame_start(3, 1'b0);
      for (int l = 0; l < 4; l++) begin
         fill_pattern(l + 4, 10);
         send_line(10, 1'b1);
         repeat (5) tick();
      end
      wait_drain();
      frame_start(0, 1'b0);
      for (int l = 0; l < 3; l++) begin
         fill_pattern(l + 8, 10);
         send_line(10, 1'b1);
         repeat (5) tick();
      end
      wait_drain();
   endtask

   task automatic test_reset_mid_run();
      frame_start(1, 1'b0);
      fill_pattern(0, 10);
      send_line(10, 1'b1);
      repeat (3) tick();
      n_checks++;
      if (dbg_rd_state !== RD_RUN) begin
         $display("FAIL mid_run_state: got %0d, required %0d", dbg_rd_state, RD_RUN);
         n_fail++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (o_de !== 1'b0 || o_hsync !== 1'b0 || o_data !== '0) begin
         $display("FAIL async_reset: de/hs = %b%b data = %0h, required 0", o_de, o_hsync, o_data);
         n_fail++;
      end
      tick();
      rst = 1'b0;
      exp_q.delete();
      tick();
   endtask

   task automatic test_overrun();
      logic [W-1:0] w;
      frame_start(1, 1'b0);
      for (int x = 0; x < HMAX + 5; x++) begin
         w = '0;
         for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'(x + c);
         line_buf[x] = w;
      end
      send_line(HMAX + 5, 1'b1);
      tick();
      n_checks++;
      if (o_ovf !== 1'b0) begin
         $display("FAIL ovf_early: o_ovf = %b, required 0", o_ovf);
         n_fail++;
      end
      fill_pattern(1, 10);
      send_line(10, 1'b0);
      tick();
      n_checks++;
      if (o_ovf !== 1'b1) begin
         $display("FAIL ovf_set: o_ovf = %b, required 1", o_ovf);
         n_fail++;
      end
      wait_drain();
      n_checks++;
      if (o_ovf !== 1'b1) begin
         $display("FAIL ovf_sticky: o_ovf = %b, required 1", o_ovf);
         n_fail++;
      end
   endtask

   initial begin
      rst     = 1'b1;
      i_ratio = '0;
      i_mode  = 1'b0;
      i_vsync = 1'b0;
      i_hsync = 1'b0;
      i_de    = 1'b0;
      i_data  = '0;
      m_ratio = 1;
      m_mode  = 1'b0;
      m_vphase = 0;
      repeat (2) tick();
      test_reset();
      test_ratio1_drop();
      test_ratio2_drop();
      test_avg_partial();
      test_avg_sat();
      test_ratio_change();
      test_reset_mid_run();
      test_overrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_scaler_pp.md
Name: line_scaler_pp

Overview:
Parametrised successor to the 1-line fixed-ratio scaler. It performs horizontal and vertical downscaling of a streaming multi-channel video input by a runtime ratio. Horizontal mode is drop or box-average. Two line banks in ping-pong arrangement let one line be read out while the next is written. The block sits between the video input timing front-end and the downstream pixel pipeline.

Parameters:
DW, 10, bits per channel
CH, 3, channels per pixel (RGB)
HMAX, 640, max input pixels per line; bank depth = ceil(HMAX/1)
MAX_RATIO, 4, largest supported ratio (2..8)
AW, $clog2(HMAX), derived localparam, RAM address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
i_ratio  in  $clog2(MAX_RATIO+1)  downscale ratio request
i_mode  in  1  0 = DROP, 1 = AVG (horizontal)
i_vsync  in  1  input frame sync, active-high
i_hsync  in  1  input line sync, active-high
i_de  in  1  input data enable
i_data  in  CH*DW  pixel; channel 0 in LSBs
o_vsync  out  1  i_vsync delayed 2 cycles
o_hsync  out  1  1-cycle pulse one cycle before each output line
o_de  out  1  output data enable
o_data  out  CH*DW  output pixel
o_ovf  out  1  sticky overrun flag; cleared only by rst

Behaviour:
- Reset, asynchronous, active-high:
  - all outputs 0
  - ratio_q = 1, mode_q = DROP
  - counters 0; read FSM = RD_IDLE; write bank = 0
- Frame latch: on the i_vsync rising edge, latch i_ratio to ratio_q and i_mode to mode_q, and clear v_cnt. i_ratio = 0 or > MAX_RATIO latches as 1. Mid-frame changes are ignored.
- Vertical: a line is kept iff v_cnt % ratio_q == 0. v_cnt increments on each i_de falling edge. Lines not kept are neither written nor emitted.
- Horizontal write, kept lines only:
  - h_cnt counts i_de pixels; grp counts 0..ratio_q-1.
  - DROP: write the pixel with grp==0 to addr h_cnt/ratio_q.
  - AVG: per-channel accumulator of width DW+$clog2(MAX_RATIO) sums the group. At grp==ratio_q-1, or at the i_de fall with a partial group, write avg = (sum*RECIP[n] + 2^15) >> 16, where n = pixels actually in the group. Saturate to 2^DW-1.
  - Pixels beyond HMAX are ignored.
- Line close: on the i_de fall of a kept line, n_out = number of words written.
  - If the read FSM is RD_IDLE, swap banks and start the read.
  - Otherwise set o_ovf and discard the line; no bank swap.
  - n_out == 0: no read is started.
- Read FSM:
  - RD_IDLE -> RD_PRIME at line close (cycle T).
  - RD_PRIME, cycle T+1: issue addr 0; o_hsync = 1.
  - RD_RUN: one address per cycle. o_de = 1 from T+2 for exactly n_out cycles, with o_data = RAM output (1-cycle RAM latency).
  - Return to RD_IDLE after the last word.
- Simultaneous write and read never target the same bank.
- A vsync rising edge during RD_RUN does not abort the readout.
- Outputs are registered. o_data holds 0 when o_de = 0.

Decomposition:
- Package scaler_pkg:
  - mode_e {MODE_DROP, MODE_AVG}
  - rd_state_e {RD_IDLE, RD_PRIME, RD_RUN}
  - RECIP table function, ceil(65536/n) for n = 1..8
  - shared DW/CH defaults
- Sub-module pingpong_line_ram:
  - two single_port_ram instances plus bank-select muxing
  - write port follows wr_bank; read port follows !wr_bank

Test Plan:
1. ratio=1, DROP, 4 lines of 10 pixels, data = line*16 + x -> each line re-emitted; o_de high 10 cycles starting 2 cycles after i_de falls; o_hsync 1 cycle earlier.
2. ratio=2, DROP, 4x10 -> 2 output lines (input lines 0, 2), 5 pixels each, x = 0, 2, 4, 6, 8.
3. ratio=3, AVG, line of 10 pixels ch0 = 0, 3, 6 … 27 -> 4 outputs: 3, 12, 21, 27. The last group has n=1.
4. AVG saturation: ratio=4, all ch = 1023 -> every output = 1023, no wrap.
5. i_ratio changed 2->3 mid-frame -> current frame stays at 2; next vsync applies 3. i_ratio = 0 -> behaves as 1.
6. rst asserted mid-RD_RUN -> o_de/o_hsync drop to 0 the same cycle. After release, with back-to-back kept lines and a readout forced longer than the line gap (HMAX-length line, 1-cycle blanking): o_ovf = 1, the second line is dropped.
